// File: rtl/sump_tx.sv
// rtl/sump_tx.sv - 8N1 UART transmitter for WIDTH-bit words, LSB byte first, with XON/XOFF pause.
module sump_tx #(
   parameter int CLK_PER_BIT = 868,
   parameter int WIDTH       = 32
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic [WIDTH-1:0] data_i,
   input  logic             stb_i,
   input  logic             xon_i,
   input  logic             xoff_i,
   output logic             rdy_o,
   output logic             tx_o
);

   localparam int NB = WIDTH / 8;
   localparam int CW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
   localparam int BW = (NB > 1) ? $clog2(NB) : 1;
   localparam logic [CW-1:0] BIT_LAST  = CW'(CLK_PER_BIT - 1);
   localparam logic [BW-1:0] BYTE_LAST = BW'(NB - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_STOP,
      S_GAP
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    bit_cnt_q, bit_cnt_d;
   logic [2:0]       bit_idx_q, bit_idx_d;
   logic [BW-1:0]    byte_cnt_q, byte_cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d;
   logic             paused_q, paused_d;
   logic             tx_q, tx_d;
   logic             bit_wrap;

   assign bit_wrap = (bit_cnt_q == BIT_LAST);
   assign rdy_o    = (state_q == S_IDLE) && !paused_q;
   assign tx_o     = tx_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q    <= S_IDLE;
         bit_cnt_q  <= '0;
         bit_idx_q  <= '0;
         byte_cnt_q <= '0;
         shift_q    <= '0;
         paused_q   <= 1'b0;
         tx_q       <= 1'b1;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         bit_idx_q  <= bit_idx_d;
         byte_cnt_q <= byte_cnt_d;
         shift_q    <= shift_d;
         paused_q   <= paused_d;
         tx_q       <= tx_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      bit_cnt_d  = bit_cnt_q;
      bit_idx_d  = bit_idx_q;
      byte_cnt_d = byte_cnt_q;
      shift_d    = shift_q;
      paused_d   = paused_q;
      tx_d       = 1'b1;

      if (xoff_i && !xon_i) begin
         paused_d = 1'b1;
      end else if (xon_i && !xoff_i) begin
         paused_d = 1'b0;
      end

      // The bit counter only runs while a bit is on the line; IDLE and GAP leave it at zero.
      if (state_q == S_START || state_q == S_DATA || state_q == S_STOP) begin
         bit_cnt_d = bit_wrap ? '0 : bit_cnt_q + 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (stb_i && rdy_o) begin
               shift_d    = data_i;
               byte_cnt_d = '0;
               bit_cnt_d  = '0;
               state_d    = S_START;
            end
         end
         S_START: begin
            if (bit_wrap) begin
               bit_idx_d = '0;
               state_d   = S_DATA;
            end
         end
         S_DATA: begin
            if (bit_wrap) begin
               shift_d   = shift_q >> 1;
               bit_idx_d = bit_idx_q + 3'd1;
               if (bit_idx_q == 3'd7) begin
                  state_d = S_STOP;
               end
            end
         end
         S_STOP: begin
            if (bit_wrap) begin
               if (byte_cnt_q == BYTE_LAST) begin
                  state_d = S_IDLE;
               end else begin
                  byte_cnt_d = byte_cnt_q + 1'b1;
                  state_d    = S_GAP;
               end
            end
         end
         S_GAP: begin
            // Pause only bites here, so a byte already on the line always finishes.
            if (!paused_q) begin
               state_d = S_START;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Line level is registered from the next state so tx_o is glitch-free.
      case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
   end

endmodule

// File: doc/sump_tx.md
Name: sump_tx

Overview:
- Downstream transmit stage of the logic-analyzer core: takes the 32-bit words the core strobes out (samples or read-back/ID data) and serializes them onto the UART TX line as four 8N1 bytes, least significant byte first.
- Provides the ready flag the core waits on.
- Honours the XON/XOFF flow-control strobes decoded from the host.

Parameters:
- CLK_PER_BIT, 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range >= 2.
- WIDTH, 32, input word width; must be a multiple of 8; bytes per word NB = WIDTH/8.

Ports:
- clk_i  input  1  system clock
- rst_i  input  1  synchronous reset, active-high
- data_i  input  WIDTH  word to transmit; sampled only on an accepted strobe
- stb_i  input  1  transmit request; accepted only when rdy_o=1
- xon_i  input  1  single-cycle strobe, resume transmission
- xoff_i  input  1  single-cycle strobe, pause transmission
- rdy_o  output  1  ready for a new word
- tx_o  output  1  serial UART line, idle high

Behaviour:
- Interface: one clock, clk_i. Reset rst_i is synchronous and active-high; it takes effect at the rising clock edge.
- Reset values: tx_o=1, rdy_o=1, state=IDLE, paused=0, bit and byte counters 0, shift register 0.
- paused flag:
  - set by xoff_i, cleared by xon_i;
  - both strobes in the same cycle: no change;
  - a strobe takes effect from the next cycle.
- rdy_o = (state==IDLE) && !paused. It is registered-state based, not combinationally dependent on stb_i.
- Accept: stb_i=1 with rdy_o=1 latches data_i into the shift register, byte counter=0, state goes to START. A stb_i while rdy_o=0 is ignored with no side effects.
- States:
  - IDLE: tx_o=1.
  - START: tx_o=0 for CLK_PER_BIT cycles.
  - DATA: 8 bits, LSB first, each CLK_PER_BIT cycles; shift right by 1 after each bit.
  - STOP: tx_o=1 for CLK_PER_BIT cycles.
  - GAP: byte boundary; tx_o=1.
- Bit timing: the bit counter counts 0..CLK_PER_BIT-1 and wraps. State/bit advance occurs on the wrap cycle.
- Latency: tx_o falls on the first cycle after the accepting edge, i.e. the start bit begins 1 cycle after stb_i is sampled.
- End of STOP:
  - byte counter == NB-1: go to IDLE; rdy_o rises on the next cycle (unless paused).
  - otherwise: increment the byte counter and go to GAP.
- GAP:
  - if !paused, go to START next cycle. An unpaused word therefore has exactly one idle-high cycle between bytes.
  - if paused, stay in GAP with tx_o=1 until paused clears, then go to START on the following cycle.
- Pause granularity: xoff never truncates a byte. The byte in flight completes including its stop bit, and the pause takes effect at the next GAP.
- Pause while IDLE: rdy_o drops, so the core holds off its next word.
- Unpaused word duration: NB*10*CLK_PER_BIT + (NB-1) cycles from the first start-bit cycle to the last stop-bit cycle inclusive.
- Byte order: byte k = data[8k+7:8k], with k=0 sent first.
- Reset mid-operation: tx_o returns high on the reset edge. Any partial byte is abandoned; no completion is signalled.
- All counters are sized to $clog2 of their range. No arithmetic overflow is permitted in the bit counter at CLK_PER_BIT=2.

Test Plan (CLK_PER_BIT=4, WIDTH=32):
- Reset: hold rst_i 2 cycles -> tx_o=1, rdy_o=1; no transitions for 50 cycles.
- Send 0x44332211 on one-cycle stb_i:
  - rdy_o=0 next cycle;
  - the UART-model decode yields 0x11,0x22,0x33,0x44, each 40 cycles;
  - 1-cycle gaps between bytes;
  - last stop bit ends 163 cycles after the start-bit begin;
  - rdy_o=1 the cycle after.
- Busy ignore: second stb_i with 0xDEADBEEF during byte 1 -> decoded stream is still exactly 0x11,0x22,0x33,0x44; no further bytes.
- Flow control:
  - xoff_i mid-byte 1 -> byte 1 (0x22) completes;
  - tx_o held high, rdy_o=0 for 100 cycles;
  - xon_i -> byte 2 start bit begins 2 cycles after the xon_i edge;
  - bytes 0x33,0x44 are correct.
- Idle pause: xoff_i in IDLE -> rdy_o=0 and stb_i ignored. Simultaneous xon_i and xoff_i leave the state unchanged. A lone xon_i -> rdy_o=1 the next cycle.
- Reset mid-frame: rst_i during DATA of byte 2 -> tx_o=1 and rdy_o=1 after the edge. A new word 0x000000A5 then transmits 0xA5,0x00,0x00,0x00 cleanly.
